// File: rtl/fetch_pkg.sv
// Shared defaults and types for the instruction-fetch prefetch queue.
package fetch_pkg;
   localparam int unsigned           DEF_XLEN     = 32;
   localparam logic [DEF_XLEN-1:0]   DEF_RESET_PC = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [DEF_XLEN-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush and occupancy count; push into a full
// FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: entries are only observed while counted valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: credit-limited in-order requests to instruction memory,
// buffered {pc, inst} delivery to decode, and redirect flush with stale drop.
//
// state | meaning
// RUN   | no stale responses pending; every response is delivered
// DRAIN | drop_cnt stale responses from before a redirect still to be discarded
module fetch_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     XLEN     = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_out,
   output logic [XLEN-1:0] inst_pc
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic [CW-1:0]   tag_cnt, inst_cnt;
   logic [XLEN-1:0] tag_head;
   logic            tag_full, tag_empty, inst_full, inst_empty;
   logic            credit, accept, drop_now, deliver;
   fetch_entry_t    push_entry, head;
   logic            unused_flags;

   // The tag queue is never flushed: its count is the number of requests
   // still owed a response, stale or not, so it doubles as the outstanding count.
   assign credit         = (tag_cnt + inst_cnt) < CW'(DEPTH);
   assign imem_req_valid = rst & ~redirect_valid & credit;
   assign imem_req_addr  = fetch_pc_q;
   assign accept         = imem_req_valid & imem_req_ready;
   assign drop_now       = imem_resp_valid & (drop_q != '0);
   assign deliver        = imem_resp_valid & ~drop_now & ~redirect_valid;

   assign push_entry = '{pc: tag_head, inst: imem_resp_data};

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_fifo (
      .clk     (clk),
      .rst_ni  (rst),
      .push_i  (accept),
      .pop_i   (imem_resp_valid),
      .flush_i (1'b0),
      .wdata_i (fetch_pc_q),
      .rdata_o (tag_head),
      .full_o  (tag_full),
      .empty_o (tag_empty),
      .count_o (tag_cnt)
   );

   sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_inst_fifo (
      .clk     (clk),
      .rst_ni  (rst),
      .push_i  (deliver),
      .pop_i   (inst_ready & ~redirect_valid),
      .flush_i (redirect_valid),
      .wdata_i (push_entry),
      .rdata_o (head),
      .full_o  (inst_full),
      .empty_o (inst_empty),
      .count_o (inst_cnt)
   );

   assign unused_flags = tag_full ^ tag_empty ^ inst_full;

   assign inst_valid = ~inst_empty;
   assign inst_out   = inst_valid ? head.inst : '0;
   assign inst_pc    = inst_valid ? head.pc   : '0;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         drop_d     = tag_cnt - CW'(imem_resp_valid);
         state_d    = (drop_d != '0) ? DRAIN : RUN;
      end else begin
         if (accept)   fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (drop_now) drop_d     = drop_q - CW'(1);
         if (state_q == DRAIN && drop_d == '0) state_d = RUN;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against a queue-based reference model
// with an in-order variable-latency memory model.
module tb_fetch_prefetch_queue;
   localparam int          DEPTH    = 4;
   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk, rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_out, inst_pc;

   fetch_prefetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_out        (inst_out),
      .inst_pc         (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; bit stale; } inflight_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
   typedef struct { logic [31:0] addr; int due; } memreq_t;

   inflight_t   m_infl[$];
   entry_t      m_q[$];
   logic [31:0] m_pc;
   memreq_t     mem_q[$];
   int          last_due, cyc;
   int          lat_min, lat_max;
   int          n_vec, n_err;
   int          first_acc, first_val, n_acc, n_val;
   logic [31:0] first_val_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic cycle_run();
      logic      exp_rv, m_acc, d_acc;
      int        due;
      inflight_t f;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(mem_q[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      @(negedge clk);
      exp_rv = !redirect_valid && ((m_infl.size() + m_q.size()) < DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", inst_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
         chk("inst_pc", inst_pc, m_q[0].pc);
         chk("inst_out", inst_out, m_q[0].inst);
      end else begin
         chk("inst_pc_idle", inst_pc, 32'h0);
         chk("inst_out_idle", inst_out, 32'h0);
      end
      d_acc = imem_req_valid && imem_req_ready;
      m_acc = exp_rv && imem_req_ready;
      if (d_acc) n_acc++;
      if (inst_valid) n_val++;
      if (first_acc < 0 && d_acc) first_acc = cyc;
      if (first_val < 0 && inst_valid) begin
         first_val    = cyc;
         first_val_pc = inst_pc;
      end
      @(posedge clk);
      if (imem_resp_valid) void'(mem_q.pop_front());
      if (d_acc) begin
         due = cyc + $urandom_range(lat_max, lat_min);
         if (due <= last_due) due = last_due + 1;
         mem_q.push_back('{addr: imem_req_addr, due: due});
         last_due = due;
      end
      if (redirect_valid) begin
         m_q.delete();
         foreach (m_infl[i]) m_infl[i].stale = 1'b1;
         if (imem_resp_valid && m_infl.size() > 0) void'(m_infl.pop_front());
         m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
         if (inst_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (imem_resp_valid && m_infl.size() > 0) begin
            f = m_infl.pop_front();
            if (!f.stale) m_q.push_back('{pc: f.pc, inst: mem_word(f.pc)});
         end
         if (m_acc) begin
            m_infl.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      inst_ready      = 1'b0;
      m_q.delete();
      m_infl.delete();
      mem_q.delete();
      m_pc      = RESET_PC;
      last_due  = cyc;
      first_acc = -1;
      first_val = -1;
      n_acc     = 0;
      n_val     = 0;
      repeat (2) @(negedge clk);
      chk("rst_inst_valid", inst_valid, 32'h0);
      chk("rst_req_valid", imem_req_valid, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_inst_out", inst_out, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      lat_min = 1;
      lat_max = 1;

      // Streaming with 1-cycle memory, then redirect mid-stream, then PC wrap.
      do_reset();
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      repeat (12) cycle_run();
      chk("first_latency", first_val - first_acc, 32'd2);
      n_val = 0;
      repeat (8) cycle_run();
      chk("steady_no_bubble", n_val, 32'd8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      cycle_run();
      redirect_valid = 1'b0;
      repeat (10) cycle_run();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF6;
      cycle_run();
      redirect_valid = 1'b0;
      repeat (10) cycle_run();

      // Decode stalled: credit stops after DEPTH requests, one pop frees one.
      do_reset();
      imem_req_ready = 1'b1;
      repeat (15) cycle_run();
      chk("fill_reqs", n_acc, 32'd4);
      inst_ready = 1'b1;
      cycle_run();
      inst_ready = 1'b0;
      repeat (6) cycle_run();
      chk("refill_reqs", n_acc, 32'd5);

      // Three requests in flight at 5-cycle latency, redirect drops them all.
      do_reset();
      lat_min = 5;
      lat_max = 5;
      inst_ready     = 1'b1;
      imem_req_ready = 1'b1;
      repeat (3) cycle_run();
      imem_req_ready = 1'b0;
      cycle_run();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      cycle_run();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      repeat (20) cycle_run();
      chk("redir_first_pc", first_val_pc, 32'h0000_0100);

      // Asynchronous reset with the queue partly filled.
      do_reset();
      lat_min = 1;
      lat_max = 1;
      imem_req_ready = 1'b1;
      repeat (4) cycle_run();
      #2;
      rst = 1'b0;
      #1;
      chk("async_inst_valid", inst_valid, 32'h0);
      chk("async_req_valid", imem_req_valid, 32'h0);
      do_reset();
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      repeat (6) cycle_run();

      // Randomized traffic blocks.
      for (int blk = 0; blk < 8; blk++) begin
         int rdy_pct, pop_pct, redir_pct;
         lat_min   = $urandom_range(3, 1);
         lat_max   = lat_min + $urandom_range(4, 0);
         rdy_pct   = $urandom_range(100, 30);
         pop_pct   = $urandom_range(100, 20);
         redir_pct = $urandom_range(8, 0);
         for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
            inst_ready     = ($urandom_range(99, 0) < pop_pct);
            redirect_valid = ($urandom_range(99, 0) < redir_pct);
            redirect_pc    = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0))
                                                         : $urandom;
            cycle_run();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the decode stage and feeds it decoded-ready {pc, instruction} pairs.
- Issues in-order word requests to a variable-latency instruction memory and buffers responses in a small queue.
- Decode pops entries through a valid/ready handshake.
- A redirect from branch resolution flushes the queue, discards in-flight stale responses and restarts fetch at the target.

Parameters:
DEPTH, 4, queue entries and maximum outstanding-plus-buffered requests (power of 2, ≥2)
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
imem_req_valid  out  1  request to instruction memory
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  word-aligned fetch address
imem_resp_valid  in  1  response beat, returned strictly in request order
imem_resp_data  in  XLEN  instruction word
redirect_valid  in  1  branch/jump taken, restart fetch
redirect_pc  in  XLEN  restart address, bits [1:0] ignored and forced 0
inst_valid  out  1  queue head valid
inst_ready  in  1  decode consumes head
inst_out  out  XLEN  head instruction
inst_pc  out  XLEN  head PC

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; state=RUN; inst_valid=0; imem_req_valid=0; inst_out and inst_pc read 0.
- Credit rule:
  - imem_req_valid = !redirect_valid && (outstanding + occupancy < DEPTH).
  - Request accepted on imem_req_valid && imem_req_ready.
  - On accept: fetch_pc += 4, wrapping modulo 2^XLEN; outstanding += 1.
- Response: outstanding -= 1 on every imem_resp_valid.
  - If drop_cnt>0: the word is discarded and drop_cnt -= 1.
  - Otherwise {pc, data} is pushed, with pc taken from an internal in-order PC tag queue.
  - Credit guarantees a push never overflows.
- Latency:
  - Request accepted cycle N, response cycle M≥N+1 → inst_valid=1 at cycle M+1.
  - Queue is registered; no combinational response-to-output path.
- Pop: inst_valid && inst_ready removes the head. Simultaneous push and pop with a full queue is legal, since credit guarantees the push slot.
- Redirect (cycle R, highest priority):
  - Queue flushed: inst_valid=0 at R+1.
  - fetch_pc ← {redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt ← outstanding − (imem_resp_valid at R ? 1 : 0); any response at R is discarded.
  - Pops at R are ignored.
  - imem_req_valid is forced 0 at R; the first new request is at R+1.
- Back-to-back redirects: the later one wins; drop_cnt is recomputed from current outstanding.
- FSM:
  - RUN → DRAIN on redirect with computed drop_cnt>0.
  - DRAIN → RUN when drop_cnt reaches 0.
  - New requests are allowed in DRAIN, subject to credit.
- Empty queue with inst_ready=1: no effect. Full credit: imem_req_valid=0 until a pop or a response frees credit.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset release but for pre-reset requests are out of scope; memory is reset together with this block.

Decomposition:
- fetch_pkg holds:
  - XLEN, RESET_PC defaults
  - fetch_state_t enum {RUN, DRAIN}
  - fetch_entry_t struct {pc, inst}
- Sub-module sync_fifo: DEPTH × width, push/pop/flush, full/empty/count. Instantiated twice: PC tag queue and instruction queue.

Test Plan:
1. Reset release, imem_req_ready=1, fixed 1-cycle response latency, inst_ready=1 → addresses 0,4,8,…; first inst_valid 2 cycles after first accept; inst_pc matches address; no bubbles in steady state.
2. inst_ready=0, memory always ready → exactly 4 requests issued; imem_req_valid stays 0; occupancy 4. Then one pop → exactly one new request (addr 0x10).
3. Three requests outstanding with 5-cycle latency, redirect_pc=0x0000_0103 → three stale responses dropped; first delivered entry has inst_pc=0x100; queue empty the cycle after redirect.
4. Redirect in the same cycle as a response and a pop → response discarded; drop_cnt = outstanding−1; next request addr = redirect target at R+1.
5. fetch_pc = 0xFFFF_FFFC accepted → next address 0x0000_0000.
6. rst pulsed low mid-stream with queue half full → inst_valid=0 and imem_req_valid=0 asynchronously; first post-reset request addr = RESET_PC.
